// File: rtl/cpu_pkg.sv
// Shared definitions for the simplified MIPS CPU and its program loader.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_TERM,
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/run_watchdog.sv
// Run-phase cycle counter; expire_o flags the cycle the count reaches MAX_CYCLES-1.
module run_watchdog #(
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && (count_q == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory, appends a halt if missing,
// then releases the CPU and stops it on halt or watchdog expiry.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [15:0] HALT_WORD  = cpu_pkg::HALT_WORD,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [15:0]           in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  cpu_run,
  input  logic [15:0]           cpu_ir,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  done,
  output logic                  error,
  output logic                  timeout
);

  import cpu_pkg::*;

  loader_state_e state_q, state_d;

  // The write pointer and load_count advance together, so one register
  // serves both; its MSB marks that every memory word has been written.
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic                  saw_halt_q, saw_halt_d;
  logic                  timeout_q, timeout_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  wd_expire;

  run_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (state_q != ST_RUN),
    .en_i     (state_q == ST_RUN),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    saw_halt_d = saw_halt_q;
    timeout_d  = timeout_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LOAD;
          ptr_d      = '0;
          saw_halt_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          addr_d  = ptr_q[ADDR_WIDTH-1:0];
          wdata_d = in_data;
          ptr_d   = ptr_q + (ADDR_WIDTH+1)'(1);
          if (in_data == HALT_WORD) saw_halt_d = 1'b1;
          if (in_last) begin
            state_d = ST_DRAIN;
          end else if (ptr_q[ADDR_WIDTH-1:0] == '1) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (saw_halt_q) begin
          state_d = ST_RUN;
        end else if (ptr_q[ADDR_WIDTH]) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b0;
        end else begin
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        we_d    = 1'b1;
        addr_d  = ptr_q[ADDR_WIDTH-1:0];
        wdata_d = HALT_WORD;
        ptr_d   = ptr_q + (ADDR_WIDTH+1)'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_ir == HALT_WORD) begin
          state_d = ST_HALTED;
        end else if (wd_expire) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      saw_halt_q <= 1'b0;
      timeout_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      saw_halt_q <= saw_halt_d;
      timeout_q  <= timeout_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = (state_q == ST_RUN);
  assign cpu_reset  = !((state_q == ST_RUN) || (state_q == ST_HALTED));
  assign load_count = ptr_q;
  assign done       = (state_q == ST_HALTED);
  assign error      = (state_q == ST_ERROR);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: default-size instance plus a tiny
// ADDR_WIDTH=2 / MAX_CYCLES=16 instance for overflow and watchdog paths.
module tb_program_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Default-size instance
  logic        start, in_valid, in_last, in_ready, imem_we;
  logic [15:0] in_data, imem_wdata, cpu_ir;
  logic [7:0]  imem_addr;
  logic        cpu_reset, cpu_run, done, error, timeout;
  logic [8:0]  load_count;

  program_loader #(
    .ADDR_WIDTH(8),
    .HALT_WORD (16'hFFFF),
    .MAX_CYCLES(1024)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .cpu_run   (cpu_run),
    .cpu_ir    (cpu_ir),
    .load_count(load_count),
    .done      (done),
    .error     (error),
    .timeout   (timeout)
  );

  // Small instance
  logic        s_start, s_in_valid, s_in_last, s_in_ready, s_imem_we;
  logic [15:0] s_in_data, s_imem_wdata, s_cpu_ir;
  logic [1:0]  s_imem_addr;
  logic        s_cpu_reset, s_cpu_run, s_done, s_error, s_timeout;
  logic [2:0]  s_load_count;

  program_loader #(
    .ADDR_WIDTH(2),
    .HALT_WORD (16'hFFFF),
    .MAX_CYCLES(16)
  ) dut_s (
    .clock     (clock),
    .reset     (reset),
    .start     (s_start),
    .in_valid  (s_in_valid),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .in_ready  (s_in_ready),
    .imem_we   (s_imem_we),
    .imem_addr (s_imem_addr),
    .imem_wdata(s_imem_wdata),
    .cpu_reset (s_cpu_reset),
    .cpu_run   (s_cpu_run),
    .cpu_ir    (s_cpu_ir),
    .load_count(s_load_count),
    .done      (s_done),
    .error     (s_error),
    .timeout   (s_timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Write logs, sampled mid-cycle
  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  logic [1:0]  swa[$];
  logic [15:0] swd[$];

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (s_imem_we === 1'b1) begin
      swa.push_back(s_imem_addr);
      swd.push_back(s_imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_s_start();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic halt_cpu();
    cpu_ir = 16'hFFFF;
    tick();
    cpu_ir = 16'h0000;
  endtask

  logic [15:0] prog8 [8];
  logic [15:0] prog6 [6];
  int unsigned k;
  int unsigned runs;

  initial begin
    reset = 1'b1;
    start = 0; in_valid = 0; in_data = '0; in_last = 0; cpu_ir = '0;
    s_start = 0; s_in_valid = 0; s_in_data = '0; s_in_last = 0; s_cpu_ir = '0;
    #23;

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_flags", {done, error, timeout}, 3'b000);
    reset = 1'b0;
    tick();

    // 8-word program ending in halt
    prog8 = '{16'h1001, 16'h2002, 16'h3003, 16'h4004,
              16'h5005, 16'h6006, 16'h7007, 16'hFFFF};
    wa.delete(); wd.delete();
    pulse_start();
    chk("t1_in_ready_load", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = prog8[i]; in_last = (i == 7);
      tick();
    end
    in_valid = 0; in_last = 0;
    chk("t1_drain_run", cpu_run, 0);
    chk("t1_drain_ready", in_ready, 0);
    tick();
    chk("t1_run_2edges", cpu_run, 1);
    chk("t1_cpu_reset_low", cpu_reset, 0);
    chk("t1_load_count", load_count, 8);
    chk("t1_nwrites", wa.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_addr%0d", i), wa[i], i);
      chk($sformatf("t1_data%0d", i), wd[i], prog8[i]);
    end
    for (int i = 0; i < 7; i++) tick();
    chk("t1_still_running", cpu_run, 1);
    halt_cpu();
    chk("t1_done", done, 1);
    chk("t1_run_off", cpu_run, 0);
    chk("t1_cpu_reset_halted", cpu_reset, 0);

    // 3-word program, halt appended
    wa.delete(); wd.delete();
    pulse_start();
    chk("t2_done_cleared", done, 0);
    chk("t2_count_cleared", load_count, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h1111 * (i + 1); in_last = (i == 2);
      tick();
    end
    in_valid = 0; in_last = 0;
    chk("t2_drain_run", cpu_run, 0);
    tick();
    chk("t2_term_run", cpu_run, 0);
    chk("t2_term_reset", cpu_reset, 1);
    tick();
    chk("t2_run_3edges", cpu_run, 1);
    chk("t2_term_we", imem_we, 1);
    chk("t2_load_count", load_count, 4);
    tick();
    chk("t2_nwrites", wa.size(), 4);
    chk("t2_addr3", wa[3], 3);
    chk("t2_data3", wd[3], 16'hFFFF);
    chk("t2_data2", wd[2], 16'h3333);
    halt_cpu();
    chk("t2_done", done, 1);

    // 6-word load with random in_valid stalls
    prog6 = '{16'hA000, 16'hA111, 16'hA222, 16'hA333, 16'hA444, 16'hFFFF};
    wa.delete(); wd.delete();
    pulse_start();
    k = 0;
    for (int c = 0; c < 200 && k < 6; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = prog6[k]; in_last = (k == 5);
      tick();
      if (in_valid) k++;
    end
    in_valid = 0; in_last = 0;
    chk("t3_all_beats", k, 6);
    tick();
    chk("t3_run", cpu_run, 1);
    chk("t3_nwrites", wa.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_addr%0d", i), wa[i], i);
      chk($sformatf("t3_data%0d", i), wd[i], prog6[i]);
    end
    halt_cpu();

    // Reset mid-RUN, then reload
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h0B00 + 16'(i); in_last = (i == 1);
      tick();
    end
    in_valid = 0; in_last = 0;
    tick(); tick(); tick();
    chk("t4_running", cpu_run, 1);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_run", cpu_run, 0);
    chk("t4_async_reset", cpu_reset, 1);
    chk("t4_async_count", load_count, 0);
    chk("t4_async_flags", {done, error, timeout, imem_we}, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    wa.delete(); wd.delete();
    pulse_start();
    in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
    tick();
    in_valid = 0; in_last = 0;
    chk("t4_count1", load_count, 1);
    chk("t4_first_addr", imem_addr, 0);
    tick();
    chk("t4_run", cpu_run, 1);
    halt_cpu();

    // Small instance: overflow without in_last
    swa.delete(); swd.delete();
    pulse_s_start();
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_data = 16'h0C00 + 16'(i); s_in_last = 1'b0;
      tick();
    end
    s_in_valid = 0;
    chk("t5_error", s_error, 1);
    chk("t5_timeout", s_timeout, 0);
    chk("t5_in_ready", s_in_ready, 0);
    chk("t5_count", s_load_count, 4);
    chk("t5_nwrites", swa.size(), 4);
    chk("t5_last_addr", swa[3], 3);
    chk("t5_last_data", swd[3], 16'h0C03);

    // Small instance: watchdog
    pulse_s_start();
    chk("t6_error_cleared", s_error, 0);
    s_in_valid = 1'b1; s_in_data = 16'h1234; s_in_last = 1'b1;
    tick();
    s_in_valid = 0; s_in_last = 0;
    for (int i = 0; i < 10 && !s_cpu_run; i++) tick();
    chk("t6_entered_run", s_cpu_run, 1);
    runs = 0;
    while (s_cpu_run && runs < 100) begin
      tick();
      runs++;
    end
    chk("t6_run_cycles", runs, 16);
    chk("t6_error", s_error, 1);
    chk("t6_timeout", s_timeout, 1);
    chk("t6_run_off", s_cpu_run, 0);

    // Small instance: exactly full, no halt -> overflow from DRAIN
    pulse_s_start();
    chk("t7_timeout_cleared", s_timeout, 0);
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_data = 16'h0D00 + 16'(i); s_in_last = (i == 3);
      tick();
    end
    s_in_valid = 0; s_in_last = 0;
    chk("t7_drain_noerr", s_error, 0);
    tick();
    chk("t7_error", s_error, 1);
    chk("t7_timeout", s_timeout, 0);
    chk("t7_count", s_load_count, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
